score_display: RTL and testbench
================================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have port CLOCK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port LOAD, input, 1 bit: request to convert POINTS; sampled on the rising edge.
REQ-004 SHALL have port POINTS, input, 8 bits: unsigned score from the scoring stage; range 0-255 SHALL be supported.
REQ-005 SHALL have port CLEAR_REC, input, 1 bit: clears the stored record.
REQ-006 SHALL have port BUSY, output, 1 bit: high while a conversion is in progress.
REQ-007 SHALL have port DONE, output, 1 bit: single-cycle pulse marking that new BCD outputs are valid.
REQ-008 SHALL have ports BCD_HUN, BCD_TEN and BCD_UNI, output, 4 bits each: decimal digits of the last converted score.
REQ-009 SHALL have port RECORD, output, 8 bits: highest score converted since reset or the last clear.
REQ-010 SHALL have port NEW_RECORD, output, 1 bit: high when the last conversion exceeded the previous record.

Function
REQ-011 SHALL implement an FSM with states IDLE and SHIFT, plus a 3-bit shift counter.
REQ-012 In IDLE with LOAD=1 at edge k, SHALL capture POINTS into an internal shift register, clear the BCD accumulator, set count=0, enter SHIFT and clear NEW_RECORD.
REQ-013 In SHIFT, each edge SHALL perform one double-dabble step: add 3 to every accumulator digit >=5, then shift {accumulator, shift register} left by 1.
REQ-014 The count SHALL increment on each SHIFT edge; on the edge where count=7, the 8th step completes and the FSM SHALL return to IDLE.
REQ-015 On that 8th edge (edge k+8), SHALL load the final digits into BCD_HUN/TEN/UNI and assert DONE for exactly one cycle.
REQ-016 BUSY SHALL be 1 exactly while the state is SHIFT, i.e. cycles k+1 through k+8; latency from the LOAD edge to valid outputs SHALL be 8 clocks.
REQ-017 BCD outputs SHALL hold their value between conversions and SHALL NOT change during SHIFT.
REQ-018 LOAD asserted while in SHIFT SHALL be ignored; it SHALL NOT be queued.
REQ-019 LOAD asserted in the cycle where DONE=1 SHALL be accepted, since the state is IDLE.
REQ-020 At the edge in REQ-015, if the captured score is strictly greater than RECORD, SHALL set RECORD to the captured score and set NEW_RECORD=1; an equal score SHALL leave both unchanged.
REQ-021 The captured score SHALL be held unchanged in a separate register for the comparison in REQ-020; POINTS changing after edge k SHALL NOT affect the result.
REQ-022 CLEAR_REC=1 at an edge SHALL set RECORD=0 and NEW_RECORD=0, and SHALL take priority over a simultaneous record update.
REQ-023 CLEAR_REC SHALL NOT affect the FSM, BUSY, DONE or the BCD outputs.
REQ-024 Accumulator width SHALL be 12 bits; digits SHALL never exceed 9 for any 8-bit input.

Reset
REQ-025 RESET=0 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE and set count=0, BUSY=0, DONE=0, all BCD outputs=0, RECORD=0 and NEW_RECORD=0.
REQ-026 RESET asserted mid-conversion SHALL abort the conversion; no DONE pulse SHALL follow.
REQ-027 The first LOAD after RESET deasserts SHALL start a conversion normally.

Verification
REQ-028 POINTS=45 with a 1-cycle LOAD -> BUSY high for 8 cycles; DONE pulses at edge +8; BCD_HUN/TEN/UNI=0/4/5; RECORD=45; NEW_RECORD=1.
REQ-029 POINTS=255, then POINTS=0 -> digits 2/5/5, then 0/0/0; RECORD stays 255; NEW_RECORD=0 after the second conversion.
REQ-030 Conversions of 30, then 12, then 30 -> NEW_RECORD=1, then 0, then 0; RECORD=30 throughout.
REQ-031 LOAD with POINTS=9, then LOAD with POINTS=99 at edge +3 -> the second request is ignored; result is 0/0/9 with a single DONE pulse.
REQ-032 CLEAR_REC at the same edge as a DONE carrying score 60 -> RECORD=0 and NEW_RECORD=0; digits are 0/6/0.
REQ-033 RESET low at edge +4 of a conversion -> all outputs read 0 immediately; no DONE follows; the next LOAD with 7 yields 0/0/7 after 8 clocks.

Source files
------------

// File: rtl/score_display.sv
`timescale 1ns/1ps
// score_display: serial double-dabble conversion of an 8-bit score to three BCD digits,
// tracking the highest score converted since reset or the last record clear.
module score_display (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       LOAD,
    input  logic [7:0] POINTS,
    input  logic       CLEAR_REC,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] BCD_HUN,
    output logic [3:0] BCD_TEN,
    output logic [3:0] BCD_UNI,
    output logic [7:0] RECORD,
    output logic       NEW_RECORD
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]  r_state;
    logic [2:0]  r_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_cap;
    logic [11:0] r_acc;
    logic [3:0]  r_hun;
    logic [3:0]  r_ten;
    logic [3:0]  r_uni;
    logic        r_done;
    logic [7:0]  r_record;
    logic        r_new;

    logic [10:0] w_adj;
    logic [11:0] w_next;
    logic        w_start;
    logic        w_last;

    // The hundreds digit never exceeds 2, so its adjusted value fits in 3 bits.
    always_comb begin
        w_adj[10:8] = r_acc[10:8] + (r_acc[11:8] >= 4'd5 ? 3'd3 : 3'd0);
        w_adj[7:4]  = r_acc[7:4]  + (r_acc[7:4]  >= 4'd5 ? 4'd3 : 4'd0);
        w_adj[3:0]  = r_acc[3:0]  + (r_acc[3:0]  >= 4'd5 ? 4'd3 : 4'd0);
        w_next      = {w_adj, r_shift[7]};
        w_start     = (r_state == IDLE) && LOAD;
        w_last      = (r_state == SHIFT) && (r_cnt == 3'd7);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_shift <= 8'd0;
            r_cap   <= 8'd0;
            r_acc   <= 12'd0;
            r_hun   <= 4'd0;
            r_ten   <= 4'd0;
            r_uni   <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_start) begin
                r_state <= SHIFT;
                r_shift <= POINTS;
                r_cap   <= POINTS;
                r_acc   <= 12'd0;
                r_cnt   <= 3'd0;
            end else if (r_state == SHIFT) begin
                r_acc   <= w_next;
                r_shift <= {r_shift[6:0], 1'b0};
                r_cnt   <= r_cnt + 3'd1;
                if (w_last) begin
                    r_state <= IDLE;
                    r_hun   <= w_next[11:8];
                    r_ten   <= w_next[7:4];
                    r_uni   <= w_next[3:0];
                end
            end
        end
    end

    // A clear wins over a simultaneous record update.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_record <= 8'd0;
            r_new    <= 1'b0;
        end else if (CLEAR_REC) begin
            r_record <= 8'd0;
            r_new    <= 1'b0;
        end else if (w_last && (r_cap > r_record)) begin
            r_record <= r_cap;
            r_new    <= 1'b1;
        end else if (w_start) begin
            r_new    <= 1'b0;
        end
    end

    assign BUSY       = (r_state == SHIFT);
    assign DONE       = r_done;
    assign BCD_HUN    = r_hun;
    assign BCD_TEN    = r_ten;
    assign BCD_UNI    = r_uni;
    assign RECORD     = r_record;
    assign NEW_RECORD = r_new;
endmodule

// File: tb/tb_score_display.sv
`timescale 1ns/1ps
// tb_score_display: table-driven conversions, hand-written corner sequences and a
// randomized run against a cycle-level reference model using decimal arithmetic.
module tb_score_display;
    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       LOAD = 1'b0;
    logic [7:0] POINTS = 8'd0;
    logic       CLEAR_REC = 1'b0;
    logic       BUSY, DONE, NEW_RECORD;
    logic [3:0] BCD_HUN, BCD_TEN, BCD_UNI;
    logic [7:0] RECORD;

    int n_checks = 0;
    int n_err = 0;

    score_display dut (
        .CLOCK(CLOCK), .RESET(RESET), .LOAD(LOAD), .POINTS(POINTS), .CLEAR_REC(CLEAR_REC),
        .BUSY(BUSY), .DONE(DONE), .BCD_HUN(BCD_HUN), .BCD_TEN(BCD_TEN), .BCD_UNI(BCD_UNI),
        .RECORD(RECORD), .NEW_RECORD(NEW_RECORD)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: a conversion occupies 8 cycles, then digits come from division.
    int         m_rem;
    logic [7:0] m_cap;
    logic       m_done, m_new;
    logic [3:0] m_h, m_t, m_u;
    logic [7:0] m_rec;
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            m_rem <= 0; m_cap <= 8'd0; m_done <= 1'b0; m_new <= 1'b0;
            m_h <= 4'd0; m_t <= 4'd0; m_u <= 4'd0; m_rec <= 8'd0;
        end else begin
            m_done <= (m_rem == 1);
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_h <= 4'(m_cap / 100);
                    m_t <= 4'((m_cap / 10) % 10);
                    m_u <= 4'(m_cap % 10);
                end
            end else if (LOAD) begin
                m_rem <= 8;
                m_cap <= POINTS;
            end
            if (CLEAR_REC) begin
                m_rec <= 8'd0; m_new <= 1'b0;
            end else if (m_rem == 1 && m_cap > m_rec) begin
                m_rec <= m_cap; m_new <= 1'b1;
            end else if (m_rem == 0 && LOAD) begin
                m_new <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] dut_vec();
        return {BUSY, DONE, BCD_HUN, BCD_TEN, BCD_UNI, RECORD, NEW_RECORD};
    endfunction

    // Called at the negedge just after the LOAD edge; returns at the DONE cycle.
    task automatic conv_wait(output int busy_n, output bit got);
        busy_n = 0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (BUSY) busy_n++;
            if (DONE) got = 1'b1;
            else @(negedge CLOCK);
        end
    endtask

    typedef struct {
        logic [7:0] points;
        bit         clr;
        logic [3:0] h, t, u;
        logic [7:0] rec;
        logic       nr;
    } vec_t;

    vec_t vecs[7];
    int   busy_n, dones;
    bit   got;

    initial begin
        vecs[0] = '{8'd45,  1'b0, 4'd0, 4'd4, 4'd5, 8'd45,  1'b1};
        vecs[1] = '{8'd255, 1'b0, 4'd2, 4'd5, 4'd5, 8'd255, 1'b1};
        vecs[2] = '{8'd0,   1'b0, 4'd0, 4'd0, 4'd0, 8'd255, 1'b0};
        vecs[3] = '{8'd30,  1'b1, 4'd0, 4'd3, 4'd0, 8'd30,  1'b1};
        vecs[4] = '{8'd12,  1'b0, 4'd0, 4'd1, 4'd2, 8'd30,  1'b0};
        vecs[5] = '{8'd30,  1'b0, 4'd0, 4'd3, 4'd0, 8'd30,  1'b0};
        vecs[6] = '{8'd9,   1'b0, 4'd0, 4'd0, 4'd9, 8'd30,  1'b0};

        #1 RESET = 1'b0;
        #1 chk("reset_state", 32'(dut_vec()), 32'd0);
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        chk("idle_after_reset", 32'(dut_vec()), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].clr) begin
                CLEAR_REC = 1'b1;
                @(negedge CLOCK);
                CLEAR_REC = 1'b0;
                chk($sformatf("v%0d_clear", i), {24'd0, RECORD}, 32'd0);
            end
            LOAD = 1'b1; POINTS = vecs[i].points;
            @(negedge CLOCK);
            LOAD = 1'b0; POINTS = 8'($urandom);
            conv_wait(busy_n, got);
            chk($sformatf("v%0d_done", i), {31'd0, got}, 32'd1);
            chk($sformatf("v%0d_busy_cycles", i), busy_n, 32'd8);
            chk($sformatf("v%0d_digits", i), {20'd0, BCD_HUN, BCD_TEN, BCD_UNI},
                {20'd0, vecs[i].h, vecs[i].t, vecs[i].u});
            chk($sformatf("v%0d_record", i), {23'd0, RECORD, NEW_RECORD},
                {23'd0, vecs[i].rec, vecs[i].nr});
            @(negedge CLOCK);
            chk($sformatf("v%0d_done_pulse", i), {31'd0, DONE}, 32'd0);
        end

        // LOAD during SHIFT is dropped.
        LOAD = 1'b1; POINTS = 8'd9;
        @(negedge CLOCK);
        LOAD = 1'b0;
        repeat (2) @(negedge CLOCK);
        LOAD = 1'b1; POINTS = 8'd99;
        @(negedge CLOCK);
        LOAD = 1'b0;
        dones = 0;
        for (int c = 0; c < 14; c++) begin
            if (DONE) dones++;
            @(negedge CLOCK);
        end
        chk("ignore_load_dones", dones, 32'd1);
        chk("ignore_load_digits", {20'd0, BCD_HUN, BCD_TEN, BCD_UNI}, 32'h009);

        // CLEAR_REC on the DONE edge of a new high score, then LOAD in the DONE cycle.
        LOAD = 1'b1; POINTS = 8'd60;
        @(negedge CLOCK);
        LOAD = 1'b0;
        repeat (7) @(negedge CLOCK);
        chk("clr_pre_done_busy", {31'd0, BUSY}, 32'd1);
        CLEAR_REC = 1'b1;
        @(negedge CLOCK);
        CLEAR_REC = 1'b0;
        chk("clr_done", {31'd0, DONE}, 32'd1);
        chk("clr_record", {23'd0, RECORD, NEW_RECORD}, 32'd0);
        chk("clr_digits", {20'd0, BCD_HUN, BCD_TEN, BCD_UNI}, 32'h060);
        LOAD = 1'b1; POINTS = 8'd123;
        @(negedge CLOCK);
        LOAD = 1'b0;
        chk("load_on_done_busy", {31'd0, BUSY}, 32'd1);
        conv_wait(busy_n, got);
        chk("load_on_done_digits", {19'd0, got, BCD_HUN, BCD_TEN, BCD_UNI}, 32'h1123);
        chk("load_on_done_record", {23'd0, RECORD, NEW_RECORD}, {23'd0, 8'd123, 1'b1});

        // Asynchronous reset mid-conversion.
        LOAD = 1'b1; POINTS = 8'd200;
        @(negedge CLOCK);
        LOAD = 1'b0;
        repeat (3) @(negedge CLOCK);
        @(posedge CLOCK);
        #2 RESET = 1'b0;
        #1 chk("async_reset_outputs", 32'(dut_vec()), 32'd0);
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLOCK);
            if (DONE || BUSY) dones++;
        end
        chk("no_done_after_reset", dones, 32'd0);
        LOAD = 1'b1; POINTS = 8'd7;
        @(negedge CLOCK);
        LOAD = 1'b0;
        conv_wait(busy_n, got);
        chk("post_reset_conv", {19'd0, got, BCD_HUN, BCD_TEN, BCD_UNI}, 32'h1007);
        chk("post_reset_busy", busy_n, 32'd8);
        chk("post_reset_record", {23'd0, RECORD, NEW_RECORD}, {23'd0, 8'd7, 1'b1});

        // Randomized run, model compared every cycle.
        for (int c = 0; c < 600; c++) begin
            @(negedge CLOCK);
            chk($sformatf("rand_c%0d", c), 32'(dut_vec()),
                32'({m_rem != 0, m_done, m_h, m_t, m_u, m_rec, m_new}));
            LOAD = ($urandom_range(0, 2) == 0);
            CLEAR_REC = ($urandom_range(0, 15) == 0);
            POINTS = ($urandom_range(0, 5) == 0) ? m_rec : 8'($urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
